// File: rtl/frv_dmem_resp.sv
// Data-memory responder: one outstanding access, programmable wait states,
// byte-strobed writes into a word SRAM, response held until the core acks it.
module frv_dmem_resp #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_addr,
  output logic        dmem_gnt,
  output logic        dmem_recv,
  input  logic        dmem_ack,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wen_q;
  logic [3:0]  strb_q;
  logic [31:0] wdata_q;
  logic [31:0] addr_q;
  logic [31:0] off;
  logic        in_range;
  logic [AW-1:0] idx;
  logic        access;
  logic [31:0] mem [DEPTH];

  // Decode works only from the latched address; the bus may move on after grant.
  assign off      = addr_q - BASE_ADDR;
  assign in_range = off < 32'(DEPTH * 4);
  assign idx      = off[AW+1:2];
  assign access   = (state == S_WAIT) && (cnt == 4'd0);
  assign dmem_gnt = dmem_req && ((state == S_IDLE) || ((state == S_RESP) && dmem_ack));

  // SRAM is never reset; a reset coinciding with the access edge suppresses the write.
  always_ff @(posedge g_clk) begin
    if (!g_reset && access && wen_q && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      dmem_recv  <= 1'b0;
      dmem_rdata <= '0;
      dmem_error <= 1'b0;
      wen_q      <= 1'b0;
      strb_q     <= 4'd0;
      wdata_q    <= '0;
      addr_q     <= '0;
    end else begin
      if (dmem_gnt) begin
        wen_q   <= dmem_wen;
        strb_q  <= dmem_strb;
        wdata_q <= dmem_wdata;
        addr_q  <= dmem_addr;
        cnt     <= 4'(WAIT_CYCLES);
      end
      case (state)
        S_IDLE: if (dmem_gnt) state <= S_WAIT;
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state      <= S_RESP;
            dmem_recv  <= 1'b1;
            dmem_rdata <= (!wen_q && in_range) ? mem[idx] : '0;
            dmem_error <= !in_range;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          // Ack with a fresh request chains straight into the next access.
          if (dmem_ack) begin
            dmem_recv  <= 1'b0;
            dmem_rdata <= '0;
            dmem_error <= 1'b0;
            state      <= dmem_gnt ? S_WAIT : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frv_dmem_resp.sv
// Directed bench for frv_dmem_resp: one instance with no wait states, one with three.
module tb_frv_dmem_resp;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        req0 = 1'b0, req3 = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  strb = 4'h0;
  logic [31:0] wdata = '0, addr = '0;
  logic        ack = 1'b0;
  logic        gnt0, recv0, err0, gnt3, recv3, err3;
  logic [31:0] rdata0, rdata3;

  int tests = 0;
  int fails = 0;

  always #5 g_clk = ~g_clk;

  frv_dmem_resp #(.DEPTH(1024), .BASE_ADDR(32'h0002_0000), .WAIT_CYCLES(0)) dut0 (
    .g_clk(g_clk), .g_reset(g_reset), .dmem_req(req0), .dmem_wen(wen),
    .dmem_strb(strb), .dmem_wdata(wdata), .dmem_addr(addr), .dmem_gnt(gnt0),
    .dmem_recv(recv0), .dmem_ack(ack), .dmem_rdata(rdata0), .dmem_error(err0));

  frv_dmem_resp #(.DEPTH(1024), .BASE_ADDR(32'h0002_0000), .WAIT_CYCLES(3)) dut3 (
    .g_clk(g_clk), .g_reset(g_reset), .dmem_req(req3), .dmem_wen(wen),
    .dmem_strb(strb), .dmem_wdata(wdata), .dmem_addr(addr), .dmem_gnt(gnt3),
    .dmem_recv(recv3), .dmem_ack(ack), .dmem_rdata(rdata3), .dmem_error(err3));

  // Full transaction on an idle instance; lat counts edges from the grant edge
  // to the first cycle with recv high (-1 if recv never came).
  task automatic do_op(input bit sel, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] a,
                       output logic [31:0] rd, output logic er, output int lat);
    @(negedge g_clk);
    wen = w; strb = s; wdata = d; addr = a;
    if (sel) req3 = 1'b1; else req0 = 1'b1;
    @(posedge g_clk);
    lat = 1;
    @(negedge g_clk);
    req0 = 1'b0; req3 = 1'b0;
    while (!(sel ? recv3 : recv0) && lat < 40) begin
      @(posedge g_clk); lat++;
      @(negedge g_clk);
    end
    if (!(sel ? recv3 : recv0)) lat = -1;
    rd = sel ? rdata3 : rdata0;
    er = sel ? err3 : err0;
    ack = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge g_clk); @(negedge g_clk);
    tests++; if (recv0 !== 1'b0)   begin fails++; $display("FAIL reset_recv0 got %b exp 0", recv0); end
    tests++; if (rdata0 !== 32'h0) begin fails++; $display("FAIL reset_rdata0 got %h exp 0", rdata0); end
    tests++; if (err0 !== 1'b0)    begin fails++; $display("FAIL reset_err0 got %b exp 0", err0); end
    tests++; if (gnt0 !== 1'b0)    begin fails++; $display("FAIL reset_gnt0 got %b exp 0", gnt0); end
    tests++; if (recv3 !== 1'b0)   begin fails++; $display("FAIL reset_recv3 got %b exp 0", recv3); end
    tests++; if (gnt3 !== 1'b0)    begin fails++; $display("FAIL reset_gnt3 got %b exp 0", gnt3); end
    g_reset = 1'b0;
  endtask

  task automatic test_raw();
    logic [31:0] rd; logic er; int lat;
    do_op(0, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0002_0010, rd, er, lat);
    tests++; if (lat !== 2)        begin fails++; $display("FAIL raw_wr_lat got %0d exp 2", lat); end
    tests++; if (rd !== 32'h0)     begin fails++; $display("FAIL raw_wr_rdata got %h exp 0", rd); end
    do_op(0, 1'b0, 4'h0, 32'h0, 32'h0002_0010, rd, er, lat);
    tests++; if (lat !== 2)        begin fails++; $display("FAIL raw_rd_lat got %0d exp 2", lat); end
    tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL raw_rd_data got %h exp deadbeef", rd); end
    tests++; if (er !== 1'b0)      begin fails++; $display("FAIL raw_rd_err got %b exp 0", er); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic er; int lat;
    do_op(0, 1'b1, 4'hF, 32'h1122_3344, 32'h0002_0014, rd, er, lat);
    do_op(0, 1'b1, 4'b0100, 32'h00AA_0000, 32'h0002_0014, rd, er, lat);
    do_op(0, 1'b0, 4'h0, 32'h0, 32'h0002_0014, rd, er, lat);
    tests++; if (rd !== 32'h11AA_3344) begin fails++; $display("FAIL strb_merge got %h exp 11aa3344", rd); end
    do_op(0, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h0002_0014, rd, er, lat);
    tests++; if (er !== 1'b0 || lat !== 2) begin fails++; $display("FAIL strb_zero_resp got err=%b lat=%0d exp err=0 lat=2", er, lat); end
    do_op(0, 1'b0, 4'h0, 32'h0, 32'h0002_0014, rd, er, lat);
    tests++; if (rd !== 32'h11AA_3344) begin fails++; $display("FAIL strb_zero_keep got %h exp 11aa3344", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat;
    do_op(0, 1'b1, 4'hF, 32'h5A5A_1234, 32'h0002_0000, rd, er, lat);
    do_op(0, 1'b0, 4'h0, 32'h0, 32'h0001_FFFC, rd, er, lat);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL oor_rd got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    do_op(0, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0002_1000, rd, er, lat);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL oor_wr got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    do_op(0, 1'b0, 4'h0, 32'h0, 32'h0002_0000, rd, er, lat);
    tests++; if (rd !== 32'h5A5A_1234 || er !== 1'b0) begin fails++; $display("FAIL oor_word0 got %h err=%b exp 5a5a1234 err=0", rd, er); end
  endtask

  task automatic test_back_to_back();
    @(negedge g_clk);
    wen = 1'b0; addr = 32'h0002_0010; req0 = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk); req0 = 1'b0;
    @(posedge g_clk);
    @(negedge g_clk);
    wen = 1'b0; addr = 32'h0002_0014; req0 = 1'b1; ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++; if (gnt0 !== 1'b0 || recv0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin
        fails++; $display("FAIL bp_hold%0d got gnt=%b recv=%b rdata=%h exp 0 1 deadbeef", i, gnt0, recv0, rdata0);
      end
      @(posedge g_clk);
      @(negedge g_clk);
    end
    ack = 1'b1;
    #1;
    tests++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL bp_same_cycle_gnt got %b exp 1", gnt0); end
    @(posedge g_clk);
    @(negedge g_clk);
    ack = 1'b0; req0 = 1'b0; addr = 32'h0;
    tests++; if (recv0 !== 1'b0) begin fails++; $display("FAIL bp_recv_drop got %b exp 0", recv0); end
    @(posedge g_clk);
    @(negedge g_clk);
    tests++; if (recv0 !== 1'b1 || rdata0 !== 32'h11AA_3344) begin
      fails++; $display("FAIL bp_next_resp got recv=%b rdata=%h exp 1 11aa3344", recv0, rdata0);
    end
    ack = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    ack = 1'b0;
  endtask

  task automatic test_reset_resp();
    logic [31:0] rd; logic er; int lat;
    @(negedge g_clk);
    wen = 1'b0; addr = 32'h0002_0010; req0 = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk); req0 = 1'b0;
    @(posedge g_clk);
    @(negedge g_clk);
    tests++; if (recv0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rstresp_pre got recv=%b rdata=%h exp 1 deadbeef", recv0, rdata0); end
    #2 g_reset = 1'b1;
    #1;
    tests++; if (recv0 !== 1'b0 || rdata0 !== 32'h0 || err0 !== 1'b0) begin
      fails++; $display("FAIL rstresp_async got recv=%b rdata=%h err=%b exp 0 0 0", recv0, rdata0, err0);
    end
    @(negedge g_clk); g_reset = 1'b0;
    do_op(0, 1'b0, 4'h0, 32'h0, 32'h0002_0010, rd, er, lat);
    tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rstresp_mem_kept got %h exp deadbeef", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat;
    do_op(1, 1'b1, 4'hF, 32'h0000_0000, 32'h0002_0020, rd, er, lat);
    tests++; if (lat !== 5) begin fails++; $display("FAIL wait_wr_lat got %0d exp 5", lat); end
    do_op(1, 1'b0, 4'h0, 32'h0, 32'h0002_0020, rd, er, lat);
    tests++; if (lat !== 5) begin fails++; $display("FAIL wait_rd_lat got %0d exp 5", lat); end
    tests++; if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL wait_rd_data got %h err=%b exp 0 0", rd, er); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    @(negedge g_clk);
    wen = 1'b1; strb = 4'hF; wdata = 32'hFFFF_FFFF; addr = 32'h0002_0020; req3 = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    req3 = 1'b0; g_reset = 1'b1;
    #1;
    tests++; if (recv3 !== 1'b0 || err3 !== 1'b0 || rdata3 !== 32'h0 || gnt3 !== 1'b0) begin
      fails++; $display("FAIL rstmid_outputs got recv=%b err=%b rdata=%h gnt=%b exp 0 0 0 0", recv3, err3, rdata3, gnt3);
    end
    repeat (4) @(posedge g_clk);
    @(negedge g_clk); g_reset = 1'b0;
    do_op(1, 1'b0, 4'h0, 32'h0, 32'h0002_0020, rd, er, lat);
    tests++; if (rd !== 32'h0 || lat !== 5) begin fails++; $display("FAIL rstmid_no_write got %h lat=%0d exp 0 lat=5", rd, lat); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_strobes();
    test_out_of_range();
    test_back_to_back();
    test_reset_resp();
    test_wait_states();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "timeout");
  end

endmodule
